// File: rtl/frame_pair_align_if.sv
// rtl/frame_pair_align_if.sv - pixel stream bundle with tuser start-of-frame marker
interface frame_pair_align_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    input  tready,
    output tlast,
    output tuser
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready,
    input  tlast,
    input  tuser
  );
endinterface

// File: rtl/frame_pair_align.sv
// rtl/frame_pair_align.sv - re-aligns previous/current frame streams on SOF and emits lockstep pairs
module frame_pair_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      resync,
  frame_pair_align_if.slave         s_prev_axis,
  frame_pair_align_if.slave         s_curr_axis,
  frame_pair_align_if.master        m_prev_axis,
  frame_pair_align_if.master        m_curr_axis,
  output logic                      locked,
  output logic [31:0]               frame_count,
  output logic [15:0]               drop_count,
  output logic [15:0]               mismatch_count
);

  typedef enum logic {
    SEARCH = 1'b0,
    PAIRED = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;

  // One output slot shared by both sides; tlast/tuser are equal on both
  // sides whenever a pair is loaded, so a single copy is kept.
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] prev_data;
  logic [DATA_WIDTH-1:0] curr_data;
  logic                  out_last;
  logic                  out_user;

  logic                  out_fire;
  logic                  space;
  logic                  prev_ready;
  logic                  curr_ready;
  logic                  load;
  logic                  mismatch;
  logic                  prev_drop;
  logic                  curr_drop;
  logic                  pair_match;

  logic [1:0]            drop_inc;
  logic [16:0]           drop_sum;
  logic [16:0]           mismatch_sum;

  assign out_fire   = out_valid && m_prev_axis.tready && m_curr_axis.tready;
  assign space      = !out_valid || out_fire;
  assign pair_match = (s_prev_axis.tuser == s_curr_axis.tuser) &&
                      (s_prev_axis.tlast == s_curr_axis.tlast);

  // Next-state and per-side handshake decode for SEARCH / PAIRED
  always_comb begin
    state_next = state;
    prev_ready = 1'b0;
    curr_ready = 1'b0;
    load       = 1'b0;
    mismatch   = 1'b0;
    prev_drop  = 1'b0;
    curr_drop  = 1'b0;
    case (state)
      SEARCH: begin
        // Each side discards non-SOF beats and parks on its SOF beat.
        prev_ready = !(s_prev_axis.tvalid && s_prev_axis.tuser);
        curr_ready = !(s_curr_axis.tvalid && s_curr_axis.tuser);
        prev_drop  = s_prev_axis.tvalid && !s_prev_axis.tuser;
        curr_drop  = s_curr_axis.tvalid && !s_curr_axis.tuser;
        if (s_prev_axis.tvalid && s_prev_axis.tuser &&
            s_curr_axis.tvalid && s_curr_axis.tuser) begin
          state_next = PAIRED;
        end
      end
      PAIRED: begin
        // Beats move only as a joined pair.
        prev_ready = space && s_curr_axis.tvalid;
        curr_ready = space && s_prev_axis.tvalid;
        if (space && s_prev_axis.tvalid && s_curr_axis.tvalid) begin
          load     = pair_match;
          mismatch = !pair_match;
        end
        if (mismatch) begin
          state_next = SEARCH;
        end
      end
      default: state_next = SEARCH;
    endcase
    if (resync) begin
      state_next = SEARCH;
    end
  end

  // Inputs are never ready while reset is held.
  assign s_prev_axis.tready = aresetn && prev_ready;
  assign s_curr_axis.tready = aresetn && curr_ready;

  assign m_prev_axis.tvalid = out_valid;
  assign m_curr_axis.tvalid = out_valid;
  assign m_prev_axis.tdata  = prev_data;
  assign m_curr_axis.tdata  = curr_data;
  assign m_prev_axis.tlast  = out_last;
  assign m_curr_axis.tlast  = out_last;
  assign m_prev_axis.tuser  = out_user;
  assign m_curr_axis.tuser  = out_user;

  assign locked = (state == PAIRED);

  assign drop_inc     = {1'b0, prev_drop} + {1'b0, curr_drop};
  assign drop_sum     = {1'b0, drop_count} + {15'd0, drop_inc};
  assign mismatch_sum = {1'b0, mismatch_count} + 17'd1;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  // Output slot: load a matched pair, otherwise empty it when it fires
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      prev_data <= '0;
      curr_data <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      prev_data <= s_prev_axis.tdata;
      curr_data <= s_curr_axis.tdata;
      out_last  <= s_prev_axis.tlast;
      out_user  <= s_prev_axis.tuser;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Status counters: frames wrap, drops and mismatches saturate
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count    <= '0;
      drop_count     <= '0;
      mismatch_count <= '0;
    end else begin
      if (load && s_prev_axis.tuser) begin
        frame_count <= frame_count + 32'd1;
      end
      if (drop_inc != 2'd0) begin
        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (mismatch) begin
        mismatch_count <= mismatch_sum[16] ? 16'hFFFF : mismatch_sum[15:0];
      end
    end
  end

endmodule
